uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first framing with optional parity and 1 or 2 stop bits,
// paced by an external baud counter that it restarts on every accepted byte.
module uart_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  output logic                 baud_sync,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned      BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_IDX  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             HAS_PAR   = 1'(PARITY != 0);
  localparam logic             PAR_INIT  = 1'(PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [BIT_W-1:0]     w_bit_idx_nxt;
  logic                 r_stop_cnt;
  logic                 w_stop_cnt_nxt;
  logic                 r_par;
  logic                 w_par_nxt;
  logic                 r_txd;
  logic                 w_txd_nxt;
  logic                 r_tx_done;
  logic                 w_tx_done_nxt;
  logic                 w_accept;

  // Handshake and status decoded straight from the state register
  assign tx_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = tx_valid && (r_state == S_IDLE);
  assign baud_sync = w_accept;
  assign txd       = r_txd;
  assign tx_done   = r_tx_done;

  // State and datapath registers; reset aborts any frame and parks the line high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_par      <= w_par_nxt;
      r_txd      <= w_txd_nxt;
      r_tx_done  <= w_tx_done_nxt;
    end
  end

  // Next-state and next-output logic; parity accumulates from bits as they leave the shifter
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_cnt_nxt = r_stop_cnt;
    w_par_nxt      = r_par;
    w_txd_nxt      = r_txd;
    w_tx_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (w_accept) begin
          w_shift_nxt    = tx_data;
          w_bit_idx_nxt  = '0;
          w_stop_cnt_nxt = 1'b0;
          w_par_nxt      = PAR_INIT;
          w_txd_nxt      = 1'b0;
          w_state_nxt    = S_START;
        end
      end

      S_START: begin
        if (baud_tick) begin
          w_txd_nxt     = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_par_nxt     = r_par ^ r_shift[0];
          w_bit_idx_nxt = '0;
          w_state_nxt   = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (r_bit_idx == LAST_IDX) begin
            if (HAS_PAR) begin
              w_txd_nxt   = r_par;
              w_state_nxt = S_PARITY;
            end else begin
              w_txd_nxt      = 1'b1;
              w_stop_cnt_nxt = 1'b0;
              w_state_nxt    = S_STOP;
            end
          end else begin
            w_txd_nxt     = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
            w_par_nxt     = r_par ^ r_shift[0];
            w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (baud_tick) begin
          w_txd_nxt      = 1'b1;
          w_stop_cnt_nxt = 1'b0;
          w_state_nxt    = S_STOP;
        end
      end

      S_STOP: begin
        w_txd_nxt = 1'b1;
        if (baud_tick) begin
          if (r_stop_cnt == LAST_STOP) begin
            w_tx_done_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_stop_cnt_nxt = r_stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_txd_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations, each paced by its own baud counter model.
module tb_uart_tx;

  localparam int TH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] w_tick;
  logic [3:0] w_sync;
  logic [3:0] w_ready;
  logic [3:0] w_txd;
  logic [3:0] w_busy;
  logic [3:0] w_done;
  logic [3:0] r_valid;
  logic [7:0] r_data;
  logic       r_force_tick;

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  // Baud counter model: restarted by baud_sync, pulses on the last cycle of each bit
  for (genvar g = 0; g < 4; g++) begin : g_baud
    logic [1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  cnt <= '0;
      else if (w_sync[g])          cnt <= '0;
      else if (cnt == 2'(TH - 1))  cnt <= '0;
      else                         cnt <= cnt + 2'd1;
    end
    assign w_tick[g] = (cnt == 2'(TH - 1)) | r_force_tick;
  end

  uart_tx u0 (
    .clk(clk), .reset(reset), .baud_tick(w_tick[0]), .baud_sync(w_sync[0]),
    .tx_data(r_data), .tx_valid(r_valid[0]), .tx_ready(w_ready[0]),
    .txd(w_txd[0]), .busy(w_busy[0]), .tx_done(w_done[0])
  );

  uart_tx #(.PARITY(1)) u1 (
    .clk(clk), .reset(reset), .baud_tick(w_tick[1]), .baud_sync(w_sync[1]),
    .tx_data(r_data), .tx_valid(r_valid[1]), .tx_ready(w_ready[1]),
    .txd(w_txd[1]), .busy(w_busy[1]), .tx_done(w_done[1])
  );

  uart_tx #(.PARITY(2)) u2 (
    .clk(clk), .reset(reset), .baud_tick(w_tick[2]), .baud_sync(w_sync[2]),
    .tx_data(r_data), .tx_valid(r_valid[2]), .tx_ready(w_ready[2]),
    .txd(w_txd[2]), .busy(w_busy[2]), .tx_done(w_done[2])
  );

  uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .baud_tick(w_tick[3]), .baud_sync(w_sync[3]),
    .tx_data(r_data[6:0]), .tx_valid(r_valid[3]), .tx_ready(w_ready[3]),
    .txd(w_txd[3]), .busy(w_busy[3]), .tx_done(w_done[3])
  );

  function automatic int db_of(input int idx);
    return (idx == 3) ? 7 : 8;
  endfunction

  function automatic int par_of(input int idx);
    return (idx == 1) ? 1 : (idx == 2) ? 2 : 0;
  endfunction

  function automatic int sb_of(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_bit(input logic b);
    for (int k = 0; k < TH; k++) exp_q.push_back(b);
  endtask

  // Idle cycles: every instance must sit idle with the line high
  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        check("idle_txd", w_txd[i], 1'b1);
        check("idle_busy", w_busy[i], 1'b0);
        check("idle_done", w_done[i], 1'b0);
        check("idle_ready", w_ready[i], 1'b1);
      end
    end
  endtask

  // Called at a negedge: offers d, checks every cycle of the frame, ends on the tx_done cycle
  task automatic send(input int idx, input logic [7:0] d, input bit keep);
    logic p;
    logic e;
    int   n;
    exp_q.delete();
    push_bit(1'b0);
    p = (par_of(idx) == 2);
    for (int b = 0; b < db_of(idx); b++) begin
      push_bit(d[b]);
      p = p ^ d[b];
    end
    if (par_of(idx) != 0) push_bit(p);
    for (int s = 0; s < sb_of(idx); s++) push_bit(1'b1);
    n = exp_q.size();

    r_data       = d;
    r_valid[idx] = 1'b1;
    #1;
    check("ready_at_accept", w_ready[idx], 1'b1);
    check("sync_at_accept", w_sync[idx], 1'b1);

    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("txd_bit", w_txd[idx], e);
      check("done_low", w_done[idx], 1'b0);
      check("ready_low", w_ready[idx], 1'b0);
      check("busy_high", w_busy[idx], 1'b1);
      check("sync_low", w_sync[idx], 1'b0);
      if (!keep) r_valid[idx] = 1'b0;
      if (c == n / 2) r_data = ~d;
    end

    @(negedge clk);
    check("done_pulse", w_done[idx], 1'b1);
    check("txd_after_frame", w_txd[idx], 1'b1);
    check("ready_handoff", w_ready[idx], 1'b1);
    check("busy_handoff", w_busy[idx], 1'b0);
    check("sync_handoff", w_sync[idx], r_valid[idx]);
  endtask

  initial begin
    reset        = 1'b0;
    r_valid      = '0;
    r_data       = '0;
    r_force_tick = 1'b0;

    idle_cycles(2);
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(3);

    send(0, 8'hA5, 1'b0);
    idle_cycles(2);
    send(1, 8'hA5, 1'b0);
    idle_cycles(2);
    send(2, 8'hA5, 1'b0);
    idle_cycles(2);
    send(3, 8'h7F, 1'b0);
    idle_cycles(2);

    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b0);
    idle_cycles(2);

    r_force_tick = 1'b1;
    idle_cycles(3);
    r_force_tick = 1'b0;
    idle_cycles(1);

    r_data     = 8'hA5;
    r_valid[0] = 1'b1;
    @(negedge clk);
    r_valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("abort_pre_busy", w_busy[0], 1'b1);
    check("abort_pre_txd", w_txd[0], 1'b0);
    reset = 1'b0;
    #1;
    check("abort_txd", w_txd[0], 1'b1);
    check("abort_busy", w_busy[0], 1'b0);
    check("abort_ready", w_ready[0], 1'b1);
    check("abort_done", w_done[0], 1'b0);
    idle_cycles(2);
    reset = 1'b1;
    send(0, 8'h55, 1'b0);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
